// File: rtl/gate_checker_if.sv
// Bundles the control/status and gate-facing signals of gate_checker.
// The master side starts sweeps and owns the gate output; the slave side is the checker.
interface gate_checker_if #(
   parameter int N_IN = 2
);
   logic            start;
   logic [N_IN-1:0] dut_in;
   logic            dut_out;
   logic            busy;
   logic            done;
   logic            pass;
   logic [N_IN:0]   err_count;
   logic            fail_valid;
   logic [N_IN-1:0] first_fail_vec;

   modport master (
      output start, dut_out,
      input  dut_in, busy, done, pass, err_count, fail_valid, first_fail_vec
   );

   modport slave (
      input  start, dut_out,
      output dut_in, busy, done, pass, err_count, fail_valid, first_fail_vec
   );
endinterface

// File: rtl/gate_checker.sv
// Exhaustive stimulus sequencer for a single-output combinational gate: sweeps every
// input vector, waits SETTLE cycles per vector and checks the output against EXPECTED.
module gate_checker #(
   parameter int                    N_IN     = 2,
   parameter int                    SETTLE   = 1,
   parameter logic [(1<<N_IN)-1:0]  EXPECTED = 4'b1110
) (
   input logic           clk,
   input logic           rst,
   gate_checker_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SAMPLE, S_DONE} state_t;

   state_t          state;
   logic [N_IN-1:0] vec;
   logic [3:0]      wait_cnt;
   logic [N_IN-1:0] dut_in;
   logic            busy;
   logic            done;
   logic            pass;
   logic [N_IN:0]   err_count;
   logic            fail_valid;
   logic [N_IN-1:0] first_fail_vec;

   logic            mismatch;
   logic [N_IN:0]   err_next;

   // err_next includes the sample being taken this cycle, so pass sees the final count.
   assign mismatch = (bus.dut_out != EXPECTED[vec]);
   assign err_next = err_count + (N_IN+1)'(mismatch);

   // NOTE: all state is written with non-blocking assignments so every register samples
   // the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_IDLE;
         vec            <= '0;
         wait_cnt       <= '0;
         dut_in         <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         err_count      <= '0;
         fail_valid     <= 1'b0;
         first_fail_vec <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  vec            <= '0;
                  dut_in         <= '0;
                  wait_cnt       <= 4'(SETTLE);
                  err_count      <= '0;
                  fail_valid     <= 1'b0;
                  first_fail_vec <= '0;
                  pass           <= 1'b0;
                  busy           <= 1'b1;
                  state          <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (wait_cnt == 4'd0) state <= S_SAMPLE;
               else                  wait_cnt <= wait_cnt - 4'd1;
            end
            S_SAMPLE: begin
               err_count <= err_next;
               if (mismatch && !fail_valid) begin
                  first_fail_vec <= vec;
                  fail_valid     <= 1'b1;
               end
               // The sweep ends on the all-ones vector, so vec never wraps.
               if (&vec) begin
                  pass  <= (err_next == '0);
                  done  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  vec      <= vec + 1'b1;
                  dut_in   <= vec + 1'b1;
                  wait_cnt <= 4'(SETTLE);
                  state    <= S_WAIT;
               end
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.dut_in         = dut_in;
   assign bus.busy           = busy;
   assign bus.done           = done;
   assign bus.pass           = pass;
   assign bus.err_count      = err_count;
   assign bus.fail_valid     = fail_valid;
   assign bus.first_fail_vec = first_fail_vec;

endmodule
